// File: rtl/seg14_scroll_mux_pkg.sv
// Shared character codes and 14-segment glyph constants for the scrolling multiplexer.
// Glyph bit order, MSB first: a b c d e f g1 g2 h i j k l m.
package seg14_scroll_mux_pkg;

  localparam logic [5:0] CH_SPACE = 6'd0;
  localparam logic [5:0] CH_E     = 6'd5;
  localparam logic [5:0] CH_H     = 6'd8;
  localparam logic [5:0] CH_I     = 6'd9;
  localparam logic [5:0] CH_K     = 6'd11;
  localparam logic [5:0] CH_O     = 6'd15;
  localparam logic [5:0] CH_T     = 6'd20;
  localparam logic [5:0] CH_2     = 6'd29;

  localparam logic [13:0] GLYPH_SPACE = 14'b000000_00_000000;
  localparam logic [13:0] GLYPH_H     = 14'b011011_11_000000;
  localparam logic [13:0] GLYPH_E     = 14'b100111_10_000000;
  localparam logic [13:0] GLYPH_I     = 14'b100100_00_010010;
  localparam logic [13:0] GLYPH_K     = 14'b000011_10_001100;
  localparam logic [13:0] GLYPH_T     = 14'b100000_00_010010;
  localparam logic [13:0] GLYPH_O     = 14'b111111_00_000000;
  localparam logic [13:0] GLYPH_2     = 14'b110110_11_000000;

endpackage

// File: rtl/seg14_scroll_mux_if.sv
// Control, message-write and display-output bundle between user logic and the multiplexer.
interface seg14_scroll_mux_if #(
  parameter int NUM_DIGITS = 12,
  parameter int MSG_DEPTH  = 32,
  parameter int PRESC_W    = 16,
  parameter int SCROLL_W   = 8
);
  localparam int AW = $clog2(MSG_DEPTH);

  logic                  en;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [5:0]            wr_char;
  logic [AW:0]           msg_len;
  logic [PRESC_W-1:0]    digit_div;
  logic                  scroll_en;
  logic [SCROLL_W-1:0]   scroll_div;
  logic [NUM_DIGITS-1:0] sel;
  logic [13:0]           segm;
  logic                  frame_tick;

  modport master (
    output en, wr_en, wr_addr, wr_char, msg_len, digit_div, scroll_en, scroll_div,
    input  sel, segm, frame_tick
  );

  modport slave (
    input  en, wr_en, wr_addr, wr_char, msg_len, digit_div, scroll_en, scroll_div,
    output sel, segm, frame_tick
  );

endinterface

// File: rtl/seg14_scroll_mux_font.sv
// Character code to 14-segment glyph lookup; codes 1..26 are A..Z, 27..36 are 0..9.
module seg14_scroll_mux_font
  import seg14_scroll_mux_pkg::*;
(
  input  logic [5:0]  code,
  output logic [13:0] glyph
);

  always_comb begin
    glyph = GLYPH_SPACE;
    case (code)
      CH_SPACE: glyph = GLYPH_SPACE;
      6'd1:     glyph = 14'b111011_11_000000;
      6'd2:     glyph = 14'b111100_01_010010;
      6'd3:     glyph = 14'b100111_00_000000;
      6'd4:     glyph = 14'b111100_00_010010;
      CH_E:     glyph = GLYPH_E;
      6'd6:     glyph = 14'b100011_10_000000;
      6'd7:     glyph = 14'b101111_01_000000;
      CH_H:     glyph = GLYPH_H;
      CH_I:     glyph = GLYPH_I;
      6'd10:    glyph = 14'b011110_00_000000;
      CH_K:     glyph = GLYPH_K;
      6'd12:    glyph = 14'b000111_00_000000;
      6'd13:    glyph = 14'b011011_00_101000;
      6'd14:    glyph = 14'b011011_00_100100;
      CH_O:     glyph = GLYPH_O;
      6'd16:    glyph = 14'b110011_11_000000;
      6'd17:    glyph = 14'b111111_00_000100;
      6'd18:    glyph = 14'b110011_11_000100;
      6'd19:    glyph = 14'b101101_11_000000;
      CH_T:     glyph = GLYPH_T;
      6'd21:    glyph = 14'b011111_00_000000;
      6'd22:    glyph = 14'b000011_00_001001;
      6'd23:    glyph = 14'b011011_00_000101;
      6'd24:    glyph = 14'b000000_00_101101;
      6'd25:    glyph = 14'b000000_00_101010;
      6'd26:    glyph = 14'b100100_00_001001;
      6'd27:    glyph = 14'b111111_00_001001;
      6'd28:    glyph = 14'b011000_00_001000;
      CH_2:     glyph = GLYPH_2;
      6'd30:    glyph = 14'b111100_11_000000;
      6'd31:    glyph = 14'b011001_11_000000;
      6'd32:    glyph = 14'b101101_11_000000;
      6'd33:    glyph = 14'b101111_11_000000;
      6'd34:    glyph = 14'b111000_00_000000;
      6'd35:    glyph = 14'b111111_11_000000;
      6'd36:    glyph = 14'b111101_11_000000;
      default:  glyph = GLYPH_SPACE;
    endcase
  end

endmodule

// File: rtl/seg14_scroll_mux.sv
// Time-multiplexed 14-segment driver: writable message buffer, digit prescaler,
// per-frame length latch and optional right-to-left scrolling. Outputs lag state by one cycle.
module seg14_scroll_mux
  import seg14_scroll_mux_pkg::*;
#(
  parameter int NUM_DIGITS = 12,
  parameter int MSG_DEPTH  = 32,
  parameter int PRESC_W    = 16,
  parameter int SCROLL_W   = 8
) (
  input logic               clk,
  input logic               rst,
  seg14_scroll_mux_if.slave bus
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);
  localparam logic [LW-1:0] DEPTH_LEN  = LW'(MSG_DEPTH);

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [DW-1:0]         digit_idx_q, digit_idx_d;
  logic [AW-1:0]         char_ptr_q, char_ptr_d;
  logic [AW-1:0]         scroll_ptr_q, scroll_ptr_d;
  logic [SCROLL_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [LW-1:0]         len_q, len_d;
  logic [5:0]            msg_q [MSG_DEPTH];
  logic [5:0]            msg_d [MSG_DEPTH];
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [13:0]           segm_q, segm_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  tick, frame_end, scroll_step;
  logic [LW-1:0]         len_clamped, frame_len, sp_next, char_next;
  logic [13:0]           glyph;

  seg14_scroll_mux_font u_font (
    .code  (msg_q[char_ptr_q]),
    .glyph (glyph)
  );

  always_comb begin
    len_clamped = (bus.msg_len > DEPTH_LEN) ? DEPTH_LEN : bus.msg_len;
    tick        = bus.en && (presc_q >= bus.digit_div);
    frame_end   = tick && (digit_idx_q == LAST_DIGIT);
    scroll_step = frame_end && bus.scroll_en && (frame_cnt_q == bus.scroll_div);
    // Length for the frame about to start; the scroll pointer wraps against it.
    frame_len   = frame_end ? len_clamped : len_q;
    sp_next     = {1'b0, scroll_ptr_q} + LW'(scroll_step);
    char_next   = {1'b0, char_ptr_q} + LW'(1);

    presc_d      = presc_q;
    digit_idx_d  = digit_idx_q;
    char_ptr_d   = char_ptr_q;
    scroll_ptr_d = scroll_ptr_q;
    frame_cnt_d  = frame_cnt_q;
    len_d        = frame_len;

    if (bus.en) begin
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    end

    if (frame_end) begin
      scroll_ptr_d = (sp_next >= frame_len) ? '0 : sp_next[AW-1:0];
      if (bus.scroll_en) begin
        frame_cnt_d = scroll_step ? '0 : frame_cnt_q + SCROLL_W'(1);
      end
      digit_idx_d = '0;
      char_ptr_d  = scroll_ptr_d;
    end else if (tick) begin
      digit_idx_d = digit_idx_q + DW'(1);
      char_ptr_d  = (char_next >= len_q) ? '0 : char_next[AW-1:0];
    end

    msg_d = msg_q;
    if (bus.wr_en) begin
      msg_d[bus.wr_addr] = bus.wr_char;
    end

    sel_d        = bus.en ? (NUM_DIGITS'(1) << digit_idx_q) : '0;
    segm_d       = ((len_q == '0) || !bus.en) ? '0 : glyph;
    frame_tick_d = frame_end;
  end

  // Length keeps tracking msg_len while held in reset so the first frame uses the value at release.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      digit_idx_q  <= '0;
      char_ptr_q   <= '0;
      scroll_ptr_q <= '0;
      frame_cnt_q  <= '0;
      len_q        <= len_clamped;
      for (int i = 0; i < MSG_DEPTH; i++) begin
        msg_q[i] <= '0;
      end
      sel_q        <= '0;
      segm_q       <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      digit_idx_q  <= digit_idx_d;
      char_ptr_q   <= char_ptr_d;
      scroll_ptr_q <= scroll_ptr_d;
      frame_cnt_q  <= frame_cnt_d;
      len_q        <= len_d;
      msg_q        <= msg_d;
      sel_q        <= sel_d;
      segm_q       <= segm_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.segm       = segm_q;
  assign bus.frame_tick = frame_tick_q;

endmodule
